fft_host_io_port: RTL and testbench

//  Device-side end of the FFT2D host data bus. Accepts NN2 inbound words on the shared

---
 rtl/fft_host_io_port.sv | 145 ++++++++++++++
 tb/tb_fft_host_io_port.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_host_io_port.sv
// Device-side FFT2D host bus port: loads a frame from the shared bus into the frame RAM,
// waits for the core, then streams results back in bit-reversed complex order.
module fft_host_io_port #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NN2        = 8192,
    parameter int unsigned ADDR_WIDTH = 13
) (
    input  logic                  i_fft_base_clock,
    input  logic                  i_fft_reset,
    input  logic                  i_fft_start,
    inout  wire  [DATA_WIDTH-1:0] io_fft_data,
    input  logic                  i_core_done,
    input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
    output logic                  o_ram_wr_en,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_wr_data,
    output logic                  o_load_done,
    output logic                  o_unload_done,
    output logic                  o_TIP,
    output logic                  o_busy,
    output logic                  o_drive_en
);

    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam int unsigned CIDX_W = ADDR_WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NN2 - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GAP    = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_PRIME  = 3'd4;
    localparam logic [2:0] S_UNLOAD = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  load_done_q, load_done_d;
    logic                  unload_done_q, unload_done_d;

    // Output index n -> RAM address: complex index bit-reversed, re/im select kept in bit 0.
    function automatic logic [ADDR_WIDTH-1:0] rd_addr(input logic [ADDR_WIDTH-1:0] n);
        logic [CIDX_W-1:0] c;
        logic [CIDX_W-1:0] r;
        c = n[ADDR_WIDTH-1:1];
        r = '0;
        for (int i = 0; i < int'(CIDX_W); i++) begin
            r[i] = c[int'(CIDX_W) - 1 - i];
        end
        return {r, n[0]};
    endfunction

    always_ff @(posedge i_fft_base_clock) begin
        if (i_fft_reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            wr_en_q       <= 1'b0;
            wr_data_q     <= '0;
            load_done_q   <= 1'b0;
            unload_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            wr_en_q       <= wr_en_d;
            wr_data_q     <= wr_data_d;
            load_done_q   <= load_done_d;
            unload_done_q <= unload_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wr_en_d       = 1'b0;
        wr_data_d     = wr_data_q;
        load_done_d   = 1'b0;
        unload_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_fft_start) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_LOAD;
                cnt_d   = '0;
            end
            // Bus word is captured here and presented to the RAM one cycle later.
            S_LOAD: begin
                wr_en_d   = 1'b1;
                addr_d    = ADDR_WIDTH'(cnt_q);
                wr_data_d = io_fft_data;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d     = S_WAIT;
                    load_done_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (i_core_done) begin
                    state_d = S_PRIME;
                    cnt_d   = '0;
                    addr_d  = rd_addr('0);
                end
            end
            S_PRIME: begin
                state_d       = S_UNLOAD;
                addr_d        = rd_addr(ADDR_WIDTH'(cnt_q + CNT_W'(1)));
                unload_done_d = (cnt_q == LAST_IDX);
            end
            // Word n is on the bus while the read for n+1 is in flight.
            S_UNLOAD: begin
                cnt_d         = cnt_q + CNT_W'(1);
                addr_d        = rd_addr(ADDR_WIDTH'(cnt_q + CNT_W'(2)));
                unload_done_d = (cnt_d == LAST_IDX);
                if (cnt_q == LAST_IDX) begin
                    state_d       = S_IDLE;
                    cnt_d         = '0;
                    addr_d        = '0;
                    unload_done_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_ram_wr_en   = wr_en_q;
    assign o_ram_addr    = addr_q;
    assign o_ram_wr_data = wr_data_q;
    assign o_load_done   = load_done_q;
    assign o_unload_done = unload_done_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_TIP         = (state_q == S_LOAD) || (state_q == S_UNLOAD);
    assign o_drive_en    = (state_q == S_UNLOAD);

    assign io_fft_data = o_drive_en ? i_ram_rd_data : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_fft_host_io_port.sv
// Bench for fft_host_io_port with a 16-word frame, a host bus driver and a 1-cycle RAM model.
module tb_fft_host_io_port;

    localparam int unsigned DW  = 16;
    localparam int unsigned NN  = 16;
    localparam int unsigned AW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          core_done;
    logic          host_en;
    logic [DW-1:0] host_data;
    logic [DW-1:0] rd_data;
    wire  [DW-1:0] io_fft_data;
    logic          o_ram_wr_en;
    logic [AW-1:0] o_ram_addr;
    logic [DW-1:0] o_ram_wr_data;
    logic          o_load_done;
    logic          o_unload_done;
    logic          o_TIP;
    logic          o_busy;
    logic          o_drive_en;

    logic [DW-1:0] words    [NN];
    logic [DW-1:0] core_ram [NN];
    logic [DW-1:0] obs      [NN];
    logic [DW-1:0] obs_prev [NN];
    int            n_cmp = 0;
    int            n_err = 0;
    int            start_left = 0;

    always #5 clk = ~clk;

    assign io_fft_data = host_en ? host_data : {DW{1'bz}};

    always @(posedge clk) rd_data <= core_ram[o_ram_addr];

    fft_host_io_port #(.DATA_WIDTH(DW), .NN2(NN), .ADDR_WIDTH(AW)) dut (
        .i_fft_base_clock(clk),
        .i_fft_reset     (rst),
        .i_fft_start     (start),
        .io_fft_data     (io_fft_data),
        .i_core_done     (core_done),
        .i_ram_rd_data   (rd_data),
        .o_ram_wr_en     (o_ram_wr_en),
        .o_ram_addr      (o_ram_addr),
        .o_ram_wr_data   (o_ram_wr_data),
        .o_load_done     (o_load_done),
        .o_unload_done   (o_unload_done),
        .o_TIP           (o_TIP),
        .o_busy          (o_busy),
        .o_drive_en      (o_drive_en)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Address of output word n: complex index c=n/2 reversed over 3 bits, real before imaginary.
    function automatic int ref_addr(input int n);
        int c;
        int rev;
        c   = n / 2;
        rev = 0;
        for (int b = 0; b < int'(AW) - 1; b++) rev = rev * 2 + ((c >> b) & 1);
        return rev * 2 + (n % 2);
    endfunction

    // Advance to the next falling edge; bus ownership is checked every cycle.
    task automatic tick();
        @(negedge clk);
        check("bus_contention", 32'(host_en & o_drive_en), 32'd0);
        check("drive_outside_transfer", 32'(o_drive_en & ~o_TIP), 32'd0);
        if (start_left > 0) start_left--;
        start = (start_left > 0);
    endtask

    task automatic load_frame(input int hold, input int abort_k, input int core_k);
        start_left = hold;
        start      = 1'b1;
        tick();
        check("gap_busy", 32'(o_busy), 32'd1);
        check("gap_tip", 32'(o_TIP), 32'd0);
        check("gap_wr_en", 32'(o_ram_wr_en), 32'd0);
        tick();
        for (int k = 0; k < int'(NN); k++) begin
            host_en   = 1'b1;
            host_data = words[k];
            core_done = (k == core_k);
            if (k == abort_k) begin
                rst = 1'b1;
                tick();
                rst     = 1'b0;
                host_en = 1'b0;
                check("abort_wr_en", 32'(o_ram_wr_en), 32'd0);
                check("abort_busy", 32'(o_busy), 32'd0);
                check("abort_load_done", 32'(o_load_done), 32'd0);
                check("abort_tip", 32'(o_TIP), 32'd0);
                tick();
                check("abort_idle_busy", 32'(o_busy), 32'd0);
                check("abort_idle_load_done", 32'(o_load_done), 32'd0);
                return;
            end
            check("load_tip", 32'(o_TIP), 32'd1);
            if (k > 0) begin
                check("wr_en", 32'(o_ram_wr_en), 32'd1);
                check("wr_addr", 32'(o_ram_addr), 32'(k - 1));
                check("wr_data", 32'(o_ram_wr_data), 32'(words[k - 1]));
                check("load_done_early", 32'(o_load_done), 32'd0);
            end
            tick();
        end
        host_en   = 1'b0;
        core_done = 1'b0;
        check("wr_en_last", 32'(o_ram_wr_en), 32'd1);
        check("wr_addr_last", 32'(o_ram_addr), 32'(NN - 1));
        check("wr_data_last", 32'(o_ram_wr_data), 32'(words[NN - 1]));
        check("load_done_last", 32'(o_load_done), 32'd1);
        check("wait_tip", 32'(o_TIP), 32'd0);
    endtask

    task automatic unload_frame(input int delay);
        for (int i = 0; i < delay; i++) begin
            check("wait_busy", 32'(o_busy), 32'd1);
            check("wait_drive", 32'(o_drive_en), 32'd0);
            tick();
            check("wait_wr_en", 32'(o_ram_wr_en), 32'd0);
        end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("prime_drive", 32'(o_drive_en), 32'd0);
        check("prime_busy", 32'(o_busy), 32'd1);
        check("prime_tip", 32'(o_TIP), 32'd0);
        tick();
        for (int n = 0; n < int'(NN); n++) begin
            check("unload_drive", 32'(o_drive_en), 32'd1);
            check("unload_bus", 32'(io_fft_data), 32'(core_ram[ref_addr(n)]));
            check("unload_done", 32'(o_unload_done), 32'(n == int'(NN) - 1));
            obs[n] = io_fft_data;
            tick();
        end
        check("post_drive", 32'(o_drive_en), 32'd0);
        check("post_busy", 32'(o_busy), 32'd0);
        check("post_unload_done", 32'(o_unload_done), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        core_done = 1'b0;
        host_en   = 1'b0;
        host_data = '0;
        for (int a = 0; a < int'(NN); a++) core_ram[a] = '0;
        tick();
        tick();
        check("rst_wr_en", 32'(o_ram_wr_en), 32'd0);
        check("rst_addr", 32'(o_ram_addr), 32'd0);
        check("rst_wr_data", 32'(o_ram_wr_data), 32'd0);
        check("rst_load_done", 32'(o_load_done), 32'd0);
        check("rst_unload_done", 32'(o_unload_done), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_tip", 32'(o_TIP), 32'd0);
        check("rst_drive", 32'(o_drive_en), 32'd0);
        rst = 1'b0;
        tick();

        // Linear load with 16'h0100+k, then identity RAM read back in bit-reversed order.
        for (int k = 0; k < int'(NN); k++) words[k] = 16'h0100 + 16'(k);
        load_frame(1, -1, -1);
        for (int a = 0; a < int'(NN); a++) core_ram[a] = 16'(a);
        unload_frame(0);
        check("identity_n2", 32'(obs[2]), 32'h8);
        check("identity_n6", 32'(obs[6]), 32'hc);

        // Core pulse during LOAD is ignored; so is one on the final LOAD edge.
        for (int k = 0; k < int'(NN); k++) words[k] = 16'($urandom);
        load_frame(1, -1, 5);
        for (int a = 0; a < int'(NN); a++) core_ram[a] = 16'($urandom);
        unload_frame(3);
        for (int k = 0; k < int'(NN); k++) words[k] = 16'($urandom);
        load_frame(1, -1, int'(NN) - 1);
        unload_frame(2);

        // Reset in the middle of LOAD, then a clean full frame.
        for (int k = 0; k < int'(NN); k++) words[k] = 16'($urandom);
        load_frame(1, 7, -1);
        for (int k = 0; k < int'(NN); k++) words[k] = 16'($urandom);
        load_frame(1, -1, -1);
        for (int a = 0; a < int'(NN); a++) core_ram[a] = 16'($urandom);
        unload_frame(1);

        // Start held for 20 cycles produces exactly one frame.
        for (int k = 0; k < int'(NN); k++) words[k] = 16'($urandom);
        load_frame(20, -1, -1);
        unload_frame(4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_start_idle", 32'(o_busy), 32'd0);
        end

        // Back-to-back frames with start right after the unload-done cycle.
        for (int k = 0; k < int'(NN); k++) words[k] = 16'($urandom);
        for (int a = 0; a < int'(NN); a++) core_ram[a] = 16'($urandom);
        load_frame(1, -1, -1);
        unload_frame(0);
        for (int n = 0; n < int'(NN); n++) obs_prev[n] = obs[n];
        load_frame(1, -1, -1);
        unload_frame(0);
        for (int n = 0; n < int'(NN); n++) check("b2b_repeat", 32'(obs[n]), 32'(obs_prev[n]));

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
